branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution in the ID stage of the 5-stage pipeline.
- Decodes the branch type and tells the datapath whether to compare rs against rt or against zero. Consumes the 2-bit compare result from the branch comparator.
- Stalls ID while branch operands are not yet forwardable, then issues a registered one-cycle PC redirect plus IF/ID flush for taken branches (static predict-not-taken).
- Keeps branch, taken and stall-cycle performance counters.

Parameters:
- PERF_W, 16, width of each performance counter; counters wrap modulo 2^PERF_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_br_type  in  3  0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BGTZ, 6 BLEZ, 7 reserved (treated as NONE)
- id_pc  in  32  PC of the ID instruction
- id_offset  in  32  sign-extended word offset
- operands_ready  in  1  forwarding unit: rs/rt values valid this cycle
- ex_stall  in  1  downstream stall; defers resolution
- cmp_result  in  2  comparator result: 2'b01 EQUAL, 2'b10 LT, 2'b11 GT, 2'b00 DEFAULT
- cmp_zero_sel  out  1  datapath drives comparator rt input with 0
- stall_id  out  1  hold PC and IF/ID register
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  32  new fetch PC
- flush_ifid  out  1  squash IF/ID contents
- perf_branches  out  PERF_W  resolved branches
- perf_taken  out  PERF_W  taken branches
- perf_stall_cycles  out  PERF_W  cycles stall_id was high

Behaviour:
- Reset: state IDLE. redirect_valid=0, redirect_pc=0, flush_ifid=0, all perf counters=0.
- cmp_zero_sel = id_valid & (id_br_type==5 | id_br_type==6). Combinational.
- is_br = id_valid & id_br_type in 1..6.
- States:
  - IDLE: if is_br & !operands_ready -> WAIT. If is_br & operands_ready & !ex_stall -> resolve this cycle, then REDIRECT if taken, else stay IDLE.
  - WAIT: stall_id=1. Leave under the same resolve rule once operands_ready & !ex_stall. If id_valid drops -> IDLE with no resolve.
  - REDIRECT: lasts exactly 1 cycle, then -> IDLE. The ID instruction in this cycle is wrong-path: not resolved, not counted, stall_id=0.
- stall_id = is_br & !operands_ready & state!=REDIRECT. Combinational, so IDLE stalls immediately in the first not-ready cycle. ex_stall does not raise stall_id; the pipeline already holds.
- Taken decode (unsigned compare):
  - BEQ: EQUAL. BNE: LT|GT. BLT: LT. BGE: EQUAL|GT. BGTZ: GT. BLEZ: EQUAL|LT.
  - cmp_result DEFAULT -> not taken for every type.
- Target = id_pc + 4 + (id_offset << 2), truncated mod 2^32 (wrap allowed).
- Latency: resolve in cycle N -> redirect_valid=1, flush_ifid=1, redirect_pc=target registered in cycle N+1, all for exactly one cycle.
  - redirect_pc holds its value afterwards. Redirect is issued even if ex_stall is high in N+1.
  - Not taken: no redirect.
- Counters, at resolve: perf_branches+1, perf_taken+1 if taken. perf_stall_cycles+1 every cycle stall_id=1. All wrap.
- Reset asserted mid-WAIT or mid-REDIRECT: immediate return to IDLE, outputs to reset values, pending redirect dropped.

Test Plan:
- BEQ, id_pc=0x100, id_offset=3, cmp=EQUAL, ready=1 -> next cycle redirect_valid=1, flush_ifid=1, redirect_pc=0x110 for one cycle; perf_branches=1, perf_taken=1.
- BNE, cmp=EQUAL -> no redirect; perf_branches=1, perf_taken=0.
- BLT with operands_ready low 3 cycles, then cmp=LT -> stall_id=1 for exactly 3 cycles; redirect the cycle after ready; perf_stall_cycles=3.
- BGTZ, id_offset=0xFFFFFFFF, id_pc=0x200 -> cmp_zero_sel=1; with cmp=GT, redirect_pc=0x200.
- BGE resolving while ex_stall=1 for 2 cycles -> no resolve until ex_stall=0, then single redirect; a branch present in the REDIRECT cycle is ignored and not counted.
- rst pulsed during WAIT, and separately in the redirect cycle -> state IDLE, redirect_valid=0, counters 0; id_pc=0xFFFFFFFC, id_offset=1, taken -> redirect_pc=0x4 (wrap).

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution control for the ID stage.
// Decodes the branch type, steers the comparator's rt input, stalls ID until
// operands are forwardable, and issues a registered one-cycle redirect plus
// IF/ID flush for taken branches (static predict-not-taken). Also keeps
// branch / taken / stall-cycle performance counters.
module branch_resolve_ctrl #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [2:0]        id_br_type,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_offset,
    input  logic              operands_ready,
    input  logic              ex_stall,
    input  logic [1:0]        cmp_result,
    output logic              cmp_zero_sel,
    output logic              stall_id,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              flush_ifid,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_taken,
    output logic [PERF_W-1:0] perf_stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BGTZ = 3'd5;
    localparam logic [2:0] BR_BLEZ = 3'd6;

    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;
    localparam logic [1:0] CMP_GT = 2'b11;

    state_t            state_q, state_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [PERF_W-1:0] perf_branches_q, perf_branches_d;
    logic [PERF_W-1:0] perf_taken_q, perf_taken_d;
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

    logic        is_br;
    logic        taken;
    logic        resolve;
    logic [31:0] target;

    // Branch presence and zero-compare steering (BGTZ/BLEZ compare rs against 0).
    always_comb begin
        is_br        = id_valid && (id_br_type >= BR_BEQ) && (id_br_type <= BR_BLEZ);
        cmp_zero_sel = id_valid && (id_br_type == BR_BGTZ || id_br_type == BR_BLEZ);
    end

    // Taken decode from the comparator result; DEFAULT (2'b00) never takes.
    always_comb begin
        taken = 1'b0;
        unique case (id_br_type)
            BR_BEQ:  taken = (cmp_result == CMP_EQ);
            BR_BNE:  taken = (cmp_result == CMP_LT) || (cmp_result == CMP_GT);
            BR_BLT:  taken = (cmp_result == CMP_LT);
            BR_BGE:  taken = (cmp_result == CMP_EQ) || (cmp_result == CMP_GT);
            BR_BGTZ: taken = (cmp_result == CMP_GT);
            BR_BLEZ: taken = (cmp_result == CMP_EQ) || (cmp_result == CMP_LT);
            default: taken = 1'b0;
        endcase
    end

    // Stall and resolve qualifiers; the REDIRECT cycle holds a wrong-path
    // instruction, so it neither stalls nor resolves.
    always_comb begin
        stall_id = is_br && !operands_ready && (state_q != S_REDIRECT);
        resolve  = is_br && operands_ready && !ex_stall && (state_q != S_REDIRECT);
        target   = id_pc + 32'd4 + {id_offset[29:0], 2'b00};
    end

    // Next-state, redirect and counter update.
    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        perf_branches_d  = perf_branches_q;
        perf_taken_d     = perf_taken_q;
        perf_stall_d     = perf_stall_q;

        if (stall_id)
            perf_stall_d = perf_stall_q + PERF_W'(1);

        if (resolve) begin
            perf_branches_d = perf_branches_q + PERF_W'(1);
            if (taken) begin
                perf_taken_d     = perf_taken_q + PERF_W'(1);
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (resolve)
                    state_d = taken ? S_REDIRECT : S_IDLE;
                else if (is_br && !operands_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!is_br)
                    state_d = S_IDLE;
                else if (resolve)
                    state_d = taken ? S_REDIRECT : S_IDLE;
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State, registered redirect outputs and counters; reset drops any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            perf_branches_q  <= '0;
            perf_taken_q     <= '0;
            perf_stall_q     <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            perf_branches_q  <= perf_branches_d;
            perf_taken_q     <= perf_taken_d;
            perf_stall_q     <= perf_stall_d;
        end
    end

    assign redirect_valid    = redirect_valid_q;
    assign flush_ifid        = redirect_valid_q;
    assign redirect_pc       = redirect_pc_q;
    assign perf_branches     = perf_branches_q;
    assign perf_taken        = perf_taken_q;
    assign perf_stall_cycles = perf_stall_q;

endmodule
